// File: rtl/as_gpio_arb.sv
// rtl/as_gpio_arb.sv - two-requester round-robin arbiter owning the GPIO register block
//
// Purpose:
//   The core data port and the JTAG debug port share one GPIO register block.
//   Only one transaction is in flight at a time, and it moves through
//   IDLE -> ACCESS -> RESP. If both ports request in the same IDLE cycle, the
//   port that did not win last time is served. The block owns DATA_OUT, DIR and
//   the synchronised DATA_IN. After every write to DATA_OUT it pulses cs_o for
//   one cycle.
//
// Register map (2-bit address):
//   0 DATA_OUT (rw)   1 DIR (rw, 1=output)   2 DATA_IN (ro)   3 STATUS
//   STATUS: bit0 = lock, bit1 = last_winner (1 = debug), other bits read 0.
//
// Optional feature, macro AS_GPIO_DBG_LOCK_EN:
//   When this macro is defined, only the debug port can write STATUS.lock.
//   While lock is set, core writes to DATA_OUT and DIR are acknowledged but
//   dropped. When the macro is undefined, lock reads 0 and all STATUS writes
//   are dropped.
//
// Ports:
//   clk_i, rst_i               clock (rising edge), asynchronous active-low reset
//   core_req_i/we_i/addr_i/wdata_i   core command, held until core_gnt_o
//   core_gnt_o, core_rvalid_o, core_rdata_o   grant, response, read data
//   dbg_*                      same set for the debug requester
//   gpio_i                     pad input (asynchronous to clk_i)
//   gpio_o, gpio_oe_o          pad output data and output enable
//   cs_o                       one-cycle strobe, gpio_o has just been written

module as_gpio_arb #(
  parameter int nr_gpios    = 8,
  parameter int sync_stages = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                core_req_i,
  input  logic                core_we_i,
  input  logic [1:0]          core_addr_i,
  input  logic [nr_gpios-1:0] core_wdata_i,
  output logic                core_gnt_o,
  output logic                core_rvalid_o,
  output logic [nr_gpios-1:0] core_rdata_o,
  input  logic                dbg_req_i,
  input  logic                dbg_we_i,
  input  logic [1:0]          dbg_addr_i,
  input  logic [nr_gpios-1:0] dbg_wdata_i,
  output logic                dbg_gnt_o,
  output logic                dbg_rvalid_o,
  output logic [nr_gpios-1:0] dbg_rdata_o,
  input  logic [nr_gpios-1:0] gpio_i,
  output logic [nr_gpios-1:0] gpio_o,
  output logic [nr_gpios-1:0] gpio_oe_o,
  output logic                cs_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [1:0] ADDR_DATA_OUT = 2'd0;
  localparam logic [1:0] ADDR_DIR      = 2'd1;
  localparam logic [1:0] ADDR_DATA_IN  = 2'd2;
  localparam logic [1:0] ADDR_STATUS   = 2'd3;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;        // 1 = debug owns the transaction
  logic                  we_q, we_d;
  logic [1:0]            addr_q, addr_d;
  logic [nr_gpios-1:0]   wdata_q, wdata_d;
  logic [nr_gpios-1:0]   data_out_q, data_out_d;
  logic [nr_gpios-1:0]   dir_q, dir_d;
  logic                  last_winner_q, last_winner_d;
  logic                  lock_q, lock_d;
  logic                  core_gnt_q, core_gnt_d;
  logic                  dbg_gnt_q, dbg_gnt_d;
  logic                  core_rvalid_q, core_rvalid_d;
  logic                  dbg_rvalid_q, dbg_rvalid_d;
  logic [nr_gpios-1:0]   core_rdata_q, core_rdata_d;
  logic [nr_gpios-1:0]   dbg_rdata_q, dbg_rdata_d;
  logic                  cs_q, cs_d;
  logic [nr_gpios-1:0]   sync_q [sync_stages];
  logic [nr_gpios-1:0]   sync_d [sync_stages];

  logic                  pick_dbg;
  logic                  any_req;
  logic                  wr_blocked;
  logic [nr_gpios-1:0]   status_val;
  logic [nr_gpios-1:0]   read_val;

  // In a tie, the port that is not last_winner is served. last_winner resets
  // to 1 (debug), so the core wins the first tie after reset.
  assign any_req  = core_req_i | dbg_req_i;
  assign pick_dbg = dbg_req_i & (~core_req_i | ~last_winner_q);

`ifdef AS_GPIO_DBG_LOCK_EN
  assign wr_blocked = lock_q & ~owner_q &
                      ((addr_q == ADDR_DATA_OUT) | (addr_q == ADDR_DIR));
`else
  assign wr_blocked = 1'b0;
`endif

  always_comb begin
    status_val    = '0;
    status_val[0] = lock_q;
    status_val[1] = last_winner_q;
  end

  // The read mux is sampled during ACCESS, before last_winner is updated. A
  // STATUS read therefore reports the winner of the previous transaction.
  always_comb begin
    read_val = '0;
    case (addr_q)
      ADDR_DATA_OUT: read_val = data_out_q;
      ADDR_DIR:      read_val = dir_q;
      ADDR_DATA_IN:  read_val = sync_q[sync_stages-1];
      ADDR_STATUS:   read_val = status_val;
      default:       read_val = '0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    data_out_d    = data_out_q;
    dir_d         = dir_q;
    last_winner_d = last_winner_q;
    lock_d        = lock_q;
    core_gnt_d    = 1'b0;
    dbg_gnt_d     = 1'b0;
    core_rvalid_d = 1'b0;
    dbg_rvalid_d  = 1'b0;
    core_rdata_d  = '0;
    dbg_rdata_d   = '0;
    cs_d          = 1'b0;

    sync_d[0] = gpio_i;
    for (int i = 1; i < sync_stages; i++) begin
      sync_d[i] = sync_q[i-1];
    end

    case (state_q)
      IDLE: begin
        if (any_req) begin
          // The command is latched here, so the transaction still completes
          // if the requester drops req before its grant.
          owner_d    = pick_dbg;
          we_d       = pick_dbg ? dbg_we_i    : core_we_i;
          addr_d     = pick_dbg ? dbg_addr_i  : core_addr_i;
          wdata_d    = pick_dbg ? dbg_wdata_i : core_wdata_i;
          core_gnt_d = ~pick_dbg;
          dbg_gnt_d  = pick_dbg;
          state_d    = ACCESS;
        end
      end

      ACCESS: begin
        last_winner_d = owner_q;
        core_rvalid_d = ~owner_q;
        dbg_rvalid_d  = owner_q;
        if (we_q) begin
          if (!wr_blocked) begin
            case (addr_q)
              ADDR_DATA_OUT: begin
                data_out_d = wdata_q;
                cs_d       = 1'b1;
              end
              ADDR_DIR: dir_d = wdata_q;
              ADDR_STATUS: begin
`ifdef AS_GPIO_DBG_LOCK_EN
                if (owner_q) lock_d = wdata_q[0];
`endif
              end
              default: ;  // DATA_IN is read-only
            endcase
          end
        end else if (owner_q) begin
          dbg_rdata_d = read_val;
        end else begin
          core_rdata_d = read_val;
        end
        state_d = RESP;
      end

      RESP: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      data_out_q    <= '0;
      dir_q         <= '0;
      last_winner_q <= 1'b1;
      lock_q        <= 1'b0;
      core_gnt_q    <= 1'b0;
      dbg_gnt_q     <= 1'b0;
      core_rvalid_q <= 1'b0;
      dbg_rvalid_q  <= 1'b0;
      core_rdata_q  <= '0;
      dbg_rdata_q   <= '0;
      cs_q          <= 1'b0;
      for (int i = 0; i < sync_stages; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      data_out_q    <= data_out_d;
      dir_q         <= dir_d;
      last_winner_q <= last_winner_d;
      lock_q        <= lock_d;
      core_gnt_q    <= core_gnt_d;
      dbg_gnt_q     <= dbg_gnt_d;
      core_rvalid_q <= core_rvalid_d;
      dbg_rvalid_q  <= dbg_rvalid_d;
      core_rdata_q  <= core_rdata_d;
      dbg_rdata_q   <= dbg_rdata_d;
      cs_q          <= cs_d;
      for (int i = 0; i < sync_stages; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign core_gnt_o    = core_gnt_q;
  assign dbg_gnt_o     = dbg_gnt_q;
  assign core_rvalid_o = core_rvalid_q;
  assign dbg_rvalid_o  = dbg_rvalid_q;
  assign core_rdata_o  = core_rdata_q;
  assign dbg_rdata_o   = dbg_rdata_q;
  assign gpio_o        = data_out_q;
  assign gpio_oe_o     = dir_q;
  assign cs_o          = cs_q;

endmodule
